sumador_serial_5bits: RTL and testbench

Bit-serial 5-bit unsigned adder for the calculator datapath, the addition counterpart of the existing ripple subtractor. It captures two 5-bit operands on a start strobe and adds them LSB-first, one bit per clock, through a single full-adder cell and a carry flip-flop. It returns a registered 6-bit sum (carry-out in bit 5) with a one-cycle done pulse. The block trades latency for area and feeds the same result mux as the subtractor.

---
 rtl/sumador_serial_5bits_pkg.sv | 22 ++
 rtl/sumador_serial_5bits_suma.sv | 15 +
 rtl/sumador_serial_5bits.sv | 124 ++++++++++++
 tb/tb_sumador_serial_5bits.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sumador_serial_5bits_pkg.sv
// Shared calculator definitions: operand width, FSM encoding and the
// majority helper used by the bit-serial full-adder cell.
package sumador_serial_5bits_pkg;

    localparam int CALC_WIDTH = 5;
    localparam int CNT_W      = $clog2(CALC_WIDTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_e;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/sumador_serial_5bits_suma.sv
// Combinational one-bit full-adder cell; carry storage lives in the caller.
module suma_0
    import sumador_serial_5bits_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = maj3(a, b, cin);

endmodule

// File: rtl/sumador_serial_5bits.sv
// Bit-serial unsigned adder: LSB-first through one full-adder cell, one bit
// per clock, with a registered WIDTH+1 result and a one-cycle done pulse.
module sumador_serial_5bits
    import sumador_serial_5bits_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   x,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   x_q, x_d;
    logic             fa_sum;
    logic             fa_cout;

    suma_0 u_suma (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .s    (fa_sum),
        .cout (fa_cout)
    );

    // Next-state and datapath update; DONE accepts a new start like IDLE.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    acc_d   = {WIDTH{1'b0}};
                    carry_d = 1'b0;
                    cnt_d   = {CW{1'b0}};
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                acc_d   = {fa_sum, acc_q[WIDTH-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_LAST) begin
                    x_d     = {fa_cout, acc_d};
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Operand shift registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_q <= {WIDTH{1'b0}};
            b_sh_q <= {WIDTH{1'b0}};
        end else begin
            a_sh_q <= a_sh_d;
            b_sh_q <= b_sh_d;
        end
    end

    // Carry flip-flop and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_q <= 1'b0;
            cnt_q   <= {CW{1'b0}};
        end else begin
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    // Partial-sum accumulator, filled from the MSB end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_q <= {WIDTH{1'b0}};
        else     acc_q <= acc_d;
    end

    // Result register; only written on completion so partial sums never show.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) x_q <= {(WIDTH+1){1'b0}};
        else     x_q <= x_d;
    end

    assign x    = x_q;
    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_sumador_serial_5bits.sv
// Self-checking bench for the bit-serial adder: directed cases plus random
// operands compared against plain a+b arithmetic and a latency of 5 cycles.
module tb_sumador_serial_5bits;

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] a;
    logic [4:0] b;
    logic [5:0] x;
    logic       busy;
    logic       done;

    int         n_checks;
    int         n_fail;
    logic [5:0] model_x;

    sumador_serial_5bits #(.WIDTH(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .x     (x),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Called at the sample slot just after the accepting edge.
    task automatic wait_done(input string tag, input logic [5:0] exp_x, input bit repulse);
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 1'b0;
        check_value({tag, "_busy_start"}, 32'(busy), 32'd1);
        check_value({tag, "_done_start"}, 32'(done), 32'd0);
        while (!seen && cyc < 12) begin
            @(posedge clk);
            #1;
            cyc++;
            if (repulse && cyc == 3) start = 1'b0;
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                check_value({tag, "_busy"}, 32'(busy), 32'd1);
                check_value({tag, "_x_hold"}, 32'(x), 32'(model_x));
            end
            if (repulse && cyc == 2) begin
                start = 1'b1;
                a     = 5'd1;
                b     = 5'd1;
            end
        end
        check_value({tag, "_timeout"}, 32'(seen), 32'd1);
        if (seen) begin
            check_value({tag, "_latency"}, 32'(cyc), 32'd5);
            check_value({tag, "_x"}, 32'(x), 32'(exp_x));
            check_value({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        end
        model_x = exp_x;
    endtask

    task automatic run_op(input logic [4:0] oa, input logic [4:0] ob, input bit repulse, input string tag);
        logic [5:0] exp_x;
        exp_x = 6'(oa) + 6'(ob);
        a     = oa;
        b     = ob;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 5'($urandom);
        b     = 5'($urandom);
        wait_done(tag, exp_x, repulse);
        if (repulse) begin
            repeat (3) begin
                @(posedge clk);
                #1;
                check_value({tag, "_no_extra_done"}, 32'(done), 32'd0);
                check_value({tag, "_idle"}, 32'(busy), 32'd0);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] ra;
        logic [4:0] rb;
        n_checks = 0;
        n_fail   = 0;
        model_x  = 6'd0;
        rst      = 1'b1;
        start    = 1'b0;
        a        = 5'd0;
        b        = 5'd0;

        #1;
        check_value("reset_x", 32'(x), 32'd0);
        check_value("reset_busy", 32'(busy), 32'd0);
        check_value("reset_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(5'd13, 5'd9, 1'b0, "add_13_9");
        run_op(5'd31, 5'd31, 1'b0, "add_31_31");
        run_op(5'd13, 5'd9, 1'b0, "add_13_9_again");
        run_op(5'd0, 5'd0, 1'b0, "add_0_0");
        run_op(5'd13, 5'd9, 1'b1, "start_in_shift");

        // Back-to-back with start held high.
        a     = 5'd5;
        b     = 5'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 5'($urandom);
        b = 5'($urandom);
        wait_done("b2b_5_3", 6'd8, 1'b0);
        a = 5'd16;
        b = 5'd16;
        @(posedge clk);
        #1;
        a = 5'($urandom);
        b = 5'($urandom);
        wait_done("b2b_16_16", 6'd32, 1'b0);
        start = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of SHIFT, then start pending at release.
        a     = 5'd13;
        b     = 5'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        check_value("midrst_x", 32'(x), 32'd0);
        check_value("midrst_busy", 32'(busy), 32'd0);
        check_value("midrst_done", 32'(done), 32'd0);
        model_x = 6'd0;
        a       = 5'd2;
        b       = 5'd2;
        start   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 5'($urandom);
        b     = 5'($urandom);
        wait_done("after_rst_2_2", 6'd4, 1'b0);

        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            ra = 5'($urandom_range(0, 31));
            rb = 5'($urandom_range(0, 31));
            run_op(ra, rb, 1'($urandom_range(0, 1)), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
